kmul_rr_arbiter: RTL and testbench

- Shares one combinational Karatsuba multiplier among NREQ requesters, e.g. the NTT butterfly, base-multiply and Barrett units of the Kyber datapath.
- Round-robin arbitrates valid/ready requests and registers the operands that drive the external multiplier.
- Captures the 2W-bit product into a response register with backpressure, and returns it with the requester index and a tag.

---
 rtl/kmul_rr_arbiter_if.sv | 30 +++
 rtl/kmul_rr_arbiter.sv | 93 +++++++++
 tb/tb_kmul_rr_arbiter.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/kmul_rr_arbiter_if.sv
// kmul_rr_arbiter_if: requester, multiplier and response signals of the shared multiplier arbiter
interface kmul_rr_arbiter_if #(
  parameter int W    = 12,
  parameter int NREQ = 4,
  parameter int TAGW = 4,
  parameter int IDW  = $clog2(NREQ)
);
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*W-1:0]    req_a;
  logic [NREQ*W-1:0]    req_b;
  logic [NREQ*TAGW-1:0] req_tag;
  logic [W-1:0]         mul_a;
  logic [W-1:0]         mul_b;
  logic [2*W-1:0]       mul_prod;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [2*W-1:0]       rsp_prod;
  logic [IDW-1:0]       rsp_id;
  logic [TAGW-1:0]      rsp_tag;
  logic [15:0]          ops_done;
  modport slave (
    input  req_valid, req_a, req_b, req_tag, mul_prod, rsp_ready,
    output req_ready, mul_a, mul_b, rsp_valid, rsp_prod, rsp_id, rsp_tag, ops_done
  );
  modport master (
    output req_valid, req_a, req_b, req_tag, mul_prod, rsp_ready,
    input  req_ready, mul_a, mul_b, rsp_valid, rsp_prod, rsp_id, rsp_tag, ops_done
  );
endinterface

// File: rtl/kmul_rr_arbiter.sv
// kmul_rr_arbiter: round-robin front end sharing one combinational multiplier, two register stages
module kmul_rr_arbiter #(
  parameter int W    = 12,
  parameter int NREQ = 4,
  parameter int TAGW = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input logic clk,
  input logic rst,
  kmul_rr_arbiter_if.slave bus
);
  logic [IDW-1:0]  ptr_q, ptr_d, gnt_id, op_id_q, rsp_id_q;
  logic [NREQ-1:0] grant;
  logic            found, accept, s1_free, s0_adv, s0_free;
  logic            op_valid_q, rsp_valid_q;
  logic [W-1:0]    op_a_q, op_b_q;
  logic [TAGW-1:0] op_tag_q, rsp_tag_q;
  logic [2*W-1:0]  rsp_prod_q;
  logic [15:0]     ops_done_q;

  // first valid requester at or after the pointer, wrapping modulo NREQ
  always_comb begin
    grant  = '0;
    gnt_id = '0;
    found  = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && bus.req_valid[(int'(ptr_q) + k) % NREQ]) begin
        found = 1'b1;
        grant[(int'(ptr_q) + k) % NREQ] = 1'b1;
        gnt_id = IDW'((int'(ptr_q) + k) % NREQ);
      end
    end
  end

  assign s1_free       = !rsp_valid_q || bus.rsp_ready;
  assign s0_adv        = op_valid_q && s1_free;
  assign s0_free       = !op_valid_q || s1_free;
  assign accept        = found && s0_free && !rst;
  assign ptr_d         = accept ? IDW'((int'(gnt_id) + 1) % NREQ) : ptr_q;
  assign bus.req_ready = rst ? '0 : (grant & {NREQ{s0_free}});
  assign bus.mul_a     = op_a_q;
  assign bus.mul_b     = op_b_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_prod  = rsp_prod_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_tag   = rsp_tag_q;
  assign bus.ops_done  = ops_done_q;

  // operand stage: load the granted request, empty when it moves on with nothing new behind it
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q      <= '0;
      op_valid_q <= 1'b0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      op_id_q    <= '0;
      op_tag_q   <= '0;
    end else begin
      ptr_q <= ptr_d;
      if (accept) begin
        op_valid_q <= 1'b1;
        op_a_q     <= bus.req_a[int'(gnt_id)*W +: W];
        op_b_q     <= bus.req_b[int'(gnt_id)*W +: W];
        op_id_q    <= gnt_id;
        op_tag_q   <= bus.req_tag[int'(gnt_id)*TAGW +: TAGW];
      end else if (s0_adv) begin
        op_valid_q <= 1'b0;
      end
    end
  end

  // response stage: capture the product on advance, hold under backpressure, count completions
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_prod_q  <= '0;
      rsp_id_q    <= '0;
      rsp_tag_q   <= '0;
      ops_done_q  <= '0;
    end else begin
      if (s0_adv) begin
        rsp_valid_q <= 1'b1;
        rsp_prod_q  <= bus.mul_prod;
        rsp_id_q    <= op_id_q;
        rsp_tag_q   <= op_tag_q;
      end else if (bus.rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
      if (rsp_valid_q && bus.rsp_ready && ops_done_q != 16'hFFFF)
        ops_done_q <= ops_done_q + 16'd1;
    end
  end
endmodule

// File: tb/tb_kmul_rr_arbiter.sv
// tb_kmul_rr_arbiter: scenario tasks checked against an in-order capacity-two queue model
module tb_kmul_rr_arbiter;
  localparam int W = 12, NREQ = 4, TAGW = 4, IDW = $clog2(NREQ);
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  kmul_rr_arbiter_if #(.W(W), .NREQ(NREQ), .TAGW(TAGW), .IDW(IDW)) bus ();
  kmul_rr_arbiter #(.W(W), .NREQ(NREQ), .TAGW(TAGW), .IDW(IDW)) dut (.clk(clk), .rst(rst), .bus(bus));
  assign bus.mul_prod = {{W{1'b0}}, bus.mul_a} * {{W{1'b0}}, bus.mul_b};

  typedef struct {
    logic [2*W-1:0]  prod;
    logic [IDW-1:0]  id;
    logic [TAGW-1:0] tag;
    bit              vis;
  } op_t;

  op_t q[$];
  op_t acc_op, exp_head;
  int mptr, mops, acc_idx, n_chk, n_fail;
  bit pop, exp_rv;
  logic [NREQ-1:0] exp_ready;

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic [TAGW-1:0] t);
    bus.req_a[i*W +: W] = a;
    bus.req_b[i*W +: W] = b;
    bus.req_tag[i*TAGW +: TAGW] = t;
  endtask

  task automatic model_eval();
    @(negedge clk);
    exp_ready = '0;
    acc_idx = -1;
    exp_rv = q.size() > 0 && q[0].vis;
    pop = exp_rv && bus.rsp_ready;
    if (exp_rv) exp_head = q[0];
    if (!rst && (q.size() < 2 || pop))
      for (int k = 0; k < NREQ; k++)
        if (acc_idx < 0 && bus.req_valid[(mptr + k) % NREQ]) acc_idx = (mptr + k) % NREQ;
    if (acc_idx >= 0) begin
      exp_ready[acc_idx] = 1'b1;
      acc_op.prod = (2*W)'(bus.req_a[acc_idx*W +: W]) * (2*W)'(bus.req_b[acc_idx*W +: W]);
      acc_op.id   = IDW'(acc_idx);
      acc_op.tag  = bus.req_tag[acc_idx*TAGW +: TAGW];
      acc_op.vis  = 1'b0;
    end
  endtask

  task automatic model_commit();
    op_t t;
    @(posedge clk);
    if (rst) begin
      q.delete();
      mptr = 0;
      mops = 0;
    end else begin
      if (pop) begin
        t = q.pop_front();
        if (mops < 65535) mops++;
      end
      if (q.size() > 0 && !q[0].vis) begin
        t = q.pop_front();
        t.vis = 1'b1;
        q.push_front(t);
      end
      if (acc_idx >= 0) begin
        q.push_back(acc_op);
        mptr = (acc_idx + 1) % NREQ;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_eval();
    model_commit();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = '1;
    model_eval();
    n_chk++; if (bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready got %b exp 0000", bus.req_ready); end
    model_commit();
    rst = 1'b0;
    bus.req_valid = '0;
    model_eval();
    n_chk++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %b exp 0", bus.rsp_valid); end
    n_chk++; if (bus.ops_done !== 16'd0) begin n_fail++; $display("FAIL reset_ops_done got %0d exp 0", bus.ops_done); end
    n_chk++; if (bus.mul_a !== '0 || bus.mul_b !== '0) begin n_fail++; $display("FAIL reset_mul got %0d,%0d exp 0,0", bus.mul_a, bus.mul_b); end
    model_commit();
  endtask

  task automatic test_single_op();
    do_reset();
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'b0001;
    set_op(0, 12'd3328, 12'd3328, 4'd5);
    model_eval();
    n_chk++; if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL single_ready got %b exp 0001", bus.req_ready); end
    model_commit();
    bus.req_valid = '0;
    model_eval();
    n_chk++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_early got %b exp 0", bus.rsp_valid); end
    model_commit();
    model_eval();
    n_chk++; if (bus.rsp_valid !== 1'b1 || bus.rsp_prod !== 24'hA90000 || bus.rsp_id !== 2'd0 || bus.rsp_tag !== 4'd5) begin
      n_fail++; $display("FAIL single_rsp got v=%b p=%h id=%0d tag=%0d exp v=1 p=a90000 id=0 tag=5", bus.rsp_valid, bus.rsp_prod, bus.rsp_id, bus.rsp_tag);
    end
    model_commit();
    model_eval();
    n_chk++; if (bus.ops_done !== 16'd1) begin n_fail++; $display("FAIL single_ops_done got %0d exp 1", bus.ops_done); end
    model_commit();
  endtask

  task automatic test_round_robin();
    do_reset();
    bus.rsp_ready = 1'b1;
    bus.req_valid = '1;
    for (int i = 0; i < NREQ; i++) set_op(i, W'($urandom), W'($urandom), TAGW'(i + 8));
    for (int c = 0; c < 12; c++) begin
      model_eval();
      n_chk++; if (bus.req_ready !== NREQ'(1 << (c % NREQ))) begin n_fail++; $display("FAIL rr_ready c=%0d got %b exp %b", c, bus.req_ready, NREQ'(1 << (c % NREQ))); end
      if (c >= 2) begin
        n_chk++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== IDW'((c - 2) % NREQ) || bus.rsp_prod !== exp_head.prod) begin
          n_fail++; $display("FAIL rr_rsp c=%0d got v=%b id=%0d p=%h exp v=1 id=%0d p=%h", c, bus.rsp_valid, bus.rsp_id, bus.rsp_prod, (c - 2) % NREQ, exp_head.prod);
        end
      end
      model_commit();
    end
    bus.req_valid = '0;
  endtask

  task automatic test_priority_rotation();
    do_reset();
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'b0010;
    model_eval();
    n_chk++; if (bus.req_ready !== 4'b0010) begin n_fail++; $display("FAIL prio_first got %b exp 0010", bus.req_ready); end
    model_commit();
    bus.req_valid = 4'b0011;
    model_eval();
    n_chk++; if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL prio_wrap got %b exp 0001", bus.req_ready); end
    model_commit();
    model_eval();
    n_chk++; if (bus.req_ready !== 4'b0010) begin n_fail++; $display("FAIL prio_next got %b exp 0010", bus.req_ready); end
    model_commit();
    bus.req_valid = '0;
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b0010;
    set_op(1, 12'd100, 12'd200, 4'd1);
    model_eval();
    n_chk++; if (bus.req_ready !== 4'b0010) begin n_fail++; $display("FAIL bp_acc0 got %b exp 0010", bus.req_ready); end
    model_commit();
    set_op(1, 12'd7, 12'd9, 4'd2);
    model_eval();
    n_chk++; if (bus.req_ready !== 4'b0010) begin n_fail++; $display("FAIL bp_acc1 got %b exp 0010", bus.req_ready); end
    model_commit();
    set_op(1, 12'd5, 12'd5, 4'd3);
    for (int c = 0; c < 5; c++) begin
      model_eval();
      n_chk++; if (bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_full_ready c=%0d got %b exp 0000", c, bus.req_ready); end
      n_chk++; if (bus.rsp_valid !== 1'b1 || bus.rsp_prod !== 24'd20000 || bus.rsp_id !== 2'd1 || bus.rsp_tag !== 4'd1) begin
        n_fail++; $display("FAIL bp_hold c=%0d got v=%b p=%0d id=%0d tag=%0d exp v=1 p=20000 id=1 tag=1", c, bus.rsp_valid, bus.rsp_prod, bus.rsp_id, bus.rsp_tag);
      end
      model_commit();
    end
    bus.rsp_ready = 1'b1;
    bus.req_valid = '0;
    model_eval();
    n_chk++; if (bus.rsp_valid !== 1'b1 || bus.rsp_prod !== 24'd20000) begin n_fail++; $display("FAIL bp_rel0 got v=%b p=%0d exp v=1 p=20000", bus.rsp_valid, bus.rsp_prod); end
    model_commit();
    model_eval();
    n_chk++; if (bus.rsp_valid !== 1'b1 || bus.rsp_prod !== 24'd63 || bus.rsp_tag !== 4'd2) begin n_fail++; $display("FAIL bp_rel1 got v=%b p=%0d tag=%0d exp v=1 p=63 tag=2", bus.rsp_valid, bus.rsp_prod, bus.rsp_tag); end
    model_commit();
    model_eval();
    n_chk++; if (bus.rsp_valid !== 1'b0 || bus.ops_done !== 16'd2) begin n_fail++; $display("FAIL bp_drained got v=%b ops=%0d exp v=0 ops=2", bus.rsp_valid, bus.ops_done); end
    model_commit();
  endtask

  task automatic test_reset_midstream();
    do_reset();
    bus.rsp_ready = 1'b0;
    bus.req_valid = '1;
    repeat (3) begin model_eval(); model_commit(); end
    rst = 1'b1;
    model_eval();
    n_chk++; if (bus.req_ready !== 4'b0000 || bus.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL mid_rst got ready=%b v=%b exp ready=0000 v=1", bus.req_ready, bus.rsp_valid); end
    model_commit();
    rst = 1'b0;
    bus.rsp_ready = 1'b1;
    model_eval();
    n_chk++; if (bus.rsp_valid !== 1'b0 || bus.ops_done !== 16'd0) begin n_fail++; $display("FAIL mid_cleared got v=%b ops=%0d exp v=0 ops=0", bus.rsp_valid, bus.ops_done); end
    n_chk++; if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL mid_ptr got %b exp 0001", bus.req_ready); end
    model_commit();
    bus.req_valid = 4'b1000;
    set_op(3, 12'd1, 12'd4095, 4'd6);
    model_eval();
    n_chk++; if (bus.req_ready !== 4'b1000) begin n_fail++; $display("FAIL mid_req3 got %b exp 1000", bus.req_ready); end
    model_commit();
    bus.req_valid = '0;
    model_eval();
    model_commit();
    model_eval();
    n_chk++; if (bus.rsp_valid !== 1'b1 || bus.rsp_prod !== 24'd4095 || bus.rsp_id !== 2'd3 || bus.rsp_tag !== 4'd6) begin
      n_fail++; $display("FAIL mid_rsp got v=%b p=%0d id=%0d tag=%0d exp v=1 p=4095 id=3 tag=6", bus.rsp_valid, bus.rsp_prod, bus.rsp_id, bus.rsp_tag);
    end
    model_commit();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      bus.req_valid = NREQ'($urandom);
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NREQ; i++) set_op(i, W'($urandom), W'($urandom), TAGW'($urandom));
      model_eval();
      n_chk++; if (bus.req_ready !== exp_ready) begin n_fail++; $display("FAIL rand_ready c=%0d got %b exp %b", c, bus.req_ready, exp_ready); end
      n_chk++; if (bus.rsp_valid !== exp_rv) begin n_fail++; $display("FAIL rand_valid c=%0d got %b exp %b", c, bus.rsp_valid, exp_rv); end
      n_chk++; if (bus.ops_done !== 16'(mops)) begin n_fail++; $display("FAIL rand_ops c=%0d got %0d exp %0d", c, bus.ops_done, mops); end
      if (exp_rv) begin
        n_chk++; if (bus.rsp_prod !== exp_head.prod || bus.rsp_id !== exp_head.id || bus.rsp_tag !== exp_head.tag) begin
          n_fail++; $display("FAIL rand_rsp c=%0d got p=%h id=%0d tag=%0d exp p=%h id=%0d tag=%0d", c, bus.rsp_prod, bus.rsp_id, bus.rsp_tag, exp_head.prod, exp_head.id, exp_head.tag);
        end
      end
      model_commit();
    end
    bus.req_valid = '0;
  endtask

  task automatic test_saturation();
    do_reset();
    bus.rsp_ready = 1'b1;
    bus.req_valid = '1;
    for (int c = 0; c < 65545; c++) begin
      model_eval();
      if (mops >= 65533) begin
        n_chk++; if (bus.ops_done !== 16'(mops)) begin n_fail++; $display("FAIL sat_ops c=%0d got %0d exp %0d", c, bus.ops_done, mops); end
      end
      model_commit();
    end
    model_eval();
    n_chk++; if (bus.ops_done !== 16'hFFFF) begin n_fail++; $display("FAIL sat_final got %h exp ffff", bus.ops_done); end
    model_commit();
    bus.req_valid = '0;
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.req_tag = '0;
    bus.rsp_ready = 1'b1;
    n_chk = 0;
    n_fail = 0;
    mptr = 0;
    mops = 0;
    #1;
    test_reset();
    test_single_op();
    test_round_robin();
    test_priority_rotation();
    test_backpressure();
    test_reset_midstream();
    test_random();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
